// File: rtl/csidh_fp_reduce_seq.sv
// Final conditional reduction r = (x >= p) ? x - p : x for CSIDH-512, one 64-bit
// limb per cycle, driving the constant-p sub / masked andadd unit with external carries.

module csidh_fp_unit #(
    parameter int XLEN = 64
) (
    input  logic            op_csidh_sub,
    input  logic            op_csidh_andadd,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      imm,
    output logic [XLEN-1:0] rd
);
    logic [XLEN-1:0] p_limb;

    always_comb begin
        case (imm)
            3'd0:    p_limb = 64'h1b81b90533c6c87b;
            3'd1:    p_limb = 64'hc2721bf457aca835;
            3'd2:    p_limb = 64'h516730cc1f0b4f25;
            3'd3:    p_limb = 64'ha7aac6c567f35507;
            3'd4:    p_limb = 64'h5afbfcc69322c9cd;
            3'd5:    p_limb = 64'hb42d083aedc88c42;
            3'd6:    p_limb = 64'hfc8ab0d15e3e4c4a;
            default: p_limb = 64'h65b48e8f740f89bf;
        endcase
    end

    // No carry/borrow in or out: the sequencer owns propagation across limbs.
    always_comb begin
        rd = '0;
        if (op_csidh_sub)
            rd = rs1 - p_limb;
        else if (op_csidh_andadd)
            rd = (p_limb & rs1) + rs2;
    end
endmodule

module csidh_fp_reduce_seq #(
    parameter int XLEN  = 64,
    parameter int NLIMB = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_limb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_limb,
    output logic            out_last,
    output logic            out_ge,
    output logic            busy
);
    typedef enum logic [1:0] {LOAD, SUB, ADD, OUT} state_t;

    state_t          state;
    logic [XLEN-1:0] lbuf [NLIMB];
    logic [2:0]      idx;
    logic            borrow;
    logic            carry;
    logic [XLEN-1:0] mask;

    logic            op_sub;
    logic            op_add;
    logic [XLEN-1:0] cur;
    logic [XLEN-1:0] unit_rs1;
    logic [XLEN-1:0] unit_rd;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] sum;
    logic            borrow_nxt;
    logic            carry_nxt;
    logic            last_idx;

    always_comb begin
        op_sub     = (state == SUB);
        op_add     = (state == ADD);
        cur        = lbuf[idx];
        last_idx   = (idx == 3'(NLIMB - 1));
        // ~mask is all-ones exactly when p has to be added back.
        unit_rs1   = op_sub ? cur : ~mask;
        diff       = unit_rd - XLEN'(borrow);
        borrow_nxt = (unit_rd > cur) | ((unit_rd == '0) & borrow);
        sum        = unit_rd + XLEN'(carry);
        carry_nxt  = (unit_rd < cur) | ((unit_rd == '1) & carry);
        out_limb   = cur;
    end

    csidh_fp_unit #(.XLEN(XLEN)) u_unit (
        .op_csidh_sub    (op_sub),
        .op_csidh_andadd (op_add),
        .rs1             (unit_rs1),
        .rs2             (cur),
        .imm             (idx),
        .rd              (unit_rd)
    );

    always_ff @(posedge clk) begin
        case (state)
            LOAD:    if (in_valid) lbuf[idx] <= in_limb;
            SUB:     lbuf[idx] <= diff;
            ADD:     lbuf[idx] <= sum;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            borrow    <= 1'b0;
            carry     <= 1'b0;
            mask      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ge    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    idx <= idx + 3'd1;
                    if (last_idx) begin
                        borrow   <= 1'b0;
                        state    <= SUB;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUB: begin
                    borrow <= borrow_nxt;
                    idx    <= idx + 3'd1;
                    if (last_idx) begin
                        // Final borrow means x < p: keep x by adding p back.
                        mask   <= borrow_nxt ? '0 : '1;
                        out_ge <= ~borrow_nxt;
                        carry  <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    carry <= carry_nxt;
                    idx   <= idx + 3'd1;
                    if (last_idx) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                default: if (out_ready) begin
                    idx      <= idx + 3'd1;
                    out_last <= (idx == 3'(NLIMB - 2));
                    if (last_idx) begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csidh_fp_reduce_seq.sv
// Scoreboarded random and directed bench for csidh_fp_reduce_seq against a 512-bit model.

module tb_csidh_fp_reduce_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_limb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_limb;
    logic        out_last;
    logic        out_ge;
    logic        busy;

    always #5 clk = ~clk;

    csidh_fp_reduce_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_limb   (in_limb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_limb  (out_limb),
        .out_last  (out_last),
        .out_ge    (out_ge),
        .busy      (busy)
    );

    localparam logic [511:0] P = {
        64'h65b48e8f740f89bf, 64'hfc8ab0d15e3e4c4a, 64'hb42d083aedc88c42, 64'h5afbfcc69322c9cd,
        64'ha7aac6c567f35507, 64'h516730cc1f0b4f25, 64'hc2721bf457aca835, 64'h1b81b90533c6c87b};

    typedef struct {
        logic [511:0] r;
        logic         ge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    function automatic exp_t model(input logic [511:0] x);
        exp_t e;
        e.ge = (x >= P);
        e.r  = e.ge ? x - P : x;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [511:0] x, input bit gaps);
        bit ok;
        int n;
        sb.push_back(model(x));
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_limb  = x[64*i +: 64];
            n = 0;
            do begin
                ok = in_ready;
                @(posedge clk); #1;
                n++;
            end while (!ok && n < 4000);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_out_last"},  64'(out_last),  64'd0);
        check({tag, "_out_ge"},    64'(out_ge),    64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every output beat against the scoreboard head.
    int          beat = 0;
    exp_t        head;
    logic        pstall = 1'b0;
    logic [63:0] plimb;
    logic        plast, pge;

    always @(negedge clk) begin
        if (rst) begin
            beat   = 0;
            pstall = 1'b0;
        end else begin
            check("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
            if (pstall && out_valid) begin
                check("stall_limb", out_limb, plimb);
                check("stall_last", 64'(out_last), 64'(plast));
                check("stall_ge",   64'(out_ge),   64'(pge));
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got limb %h expected no output", out_limb);
                end else begin
                    head = sb[0];
                    check("out_limb", out_limb, head.r[64*beat +: 64]);
                    check("out_last", 64'(out_last), 64'(beat == 7));
                    check("out_ge",   64'(out_ge),   64'(head.ge));
                    if (out_ready) begin
                        if (beat == 7) begin
                            void'(sb.pop_front());
                            beat = 0;
                        end else begin
                            beat++;
                        end
                    end
                end
            end
            pstall = out_valid && !out_ready;
            plimb  = out_limb;
            plast  = out_last;
            pge    = out_ge;
        end
    end

    initial begin
        logic [511:0] x;
        logic [512:0] twop;
        int n;
        twop = {P, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // x = 0: latency and an unbroken 8-beat burst.
        rdy_mode = 0;
        @(posedge clk); #1;
        send('0, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_out_cycle", 64'(n + 1), 64'd17);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            check("burst_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        check("burst_end_valid", 64'(out_valid), 64'd0);
        check("burst_end_ready", 64'(in_ready), 64'd1);
        wait_drain();

        // Boundary values around p and 2p.
        send(P, 1'b0);
        send(P - 512'd1, 1'b0);
        send(twop[511:0] - 512'd1, 1'b0);
        send(P + 512'd1, 1'b0);
        wait_drain();

        // Random x in [0, 2p) with input gaps and output backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 1000; t++) begin
            for (int k = 0; k < 16; k++) x[32*k +: 32] = $urandom;
            if ({1'b0, x} >= twop) x = x - twop[511:0];
            send(x, 1'b1);
        end
        wait_drain();

        // Abort mid-SUB, then recover.
        rdy_mode = 0;
        send(P + 512'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort_sub");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(P + 512'd5, 1'b0);
        wait_drain();

        // Abort mid-OUT under backpressure, then recover.
        rdy_mode = 1;
        send(twop[511:0] - 512'd3, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_out_reached", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("abort_out");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        send(P + 512'd5, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
